// File: rtl/cgra_mem_pkg.sv
// Shared types and defaults for the CGRA tile data-memory arbiter.
package cgra_mem_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 64;

    // Bit value replicated across pe_rdata when a read is forced to complete.
    localparam logic DONE_RDATA_ON_TIMEOUT = 1'b0;

endpackage

// File: rtl/pe_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant, with wrap.
module rr_pick #(
    parameter  int NUM_PE = 4,
    localparam int IW     = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req_vec,
    input  logic [IW-1:0]     last_grant,
    output logic              found,
    output logic [IW-1:0]     idx
);

    int cand;

    // Walk the candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_PE; k >= 1; k--) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_PE) begin
                cand = cand - NUM_PE;
            end
            if (req_vec[IW'(cand)]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one tile data-memory port among NUM_PE processing
// elements. One transaction at a time: IDLE picks, ISSUE presents the request,
// WAIT collects completion, DONE pulses the response back to the granted PE.
//
// Handshakes: a PE holds pe_read/pe_write (with address/data) until it sees its
// one-cycle pe_ack and drops the request on that same edge. Toward memory,
// mem_req and its payload stay stable until the cycle mem_ready is high; the
// request is accepted on that edge. Completion is the first mem_rvalid seen in a
// later cycle (a mem_rvalid coincident with mem_ready is not a completion).
module pe_mem_arbiter
    import cgra_mem_pkg::*;
#(
    parameter  int NUM_PE  = 4,
    parameter  int AW      = DEF_AW,
    parameter  int DW      = DEF_DW,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IW      = $clog2(NUM_PE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_PE-1:0]  pe_read,
    input  logic [NUM_PE-1:0]  pe_write,
    input  logic [NUM_PE*AW-1:0] pe_addr,
    input  logic [NUM_PE*DW-1:0] pe_wdata,
    output logic [NUM_PE-1:0]  pe_ack,
    output logic [NUM_PE-1:0]  pe_data_ready,
    output logic [DW-1:0]      pe_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [DW-1:0]      mem_rdata,
    output logic [IW-1:0]      grant_id,
    output logic               busy,
    output logic               err_proto,
    output logic               err_timeout,
    output arb_state_e         dbg_state
);

    localparam int CW = $clog2(TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [NUM_PE-1:0]   req_vec;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                grant_now;
    logic                complete;
    logic                timeout_hit;
    logic                cnt_expired;

    logic [IW-1:0]       id_q;
    logic [IW-1:0]       last_grant_q;
    logic [IW-1:0]       grant_id_q;
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;
    logic [CW-1:0]       cnt_q;
    logic [DW-1:0]       rdata_q;
    logic                err_proto_q;
    logic                err_timeout_q;

    assign req_vec     = pe_read | pe_write;
    assign grant_now   = (state_q == ST_IDLE) && pick_found;
    assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));

    rr_pick #(
        .NUM_PE (NUM_PE)
    ) u_pick (
        .req_vec    (req_vec),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion wins over timeout in the same WAIT cycle.
    always_comb begin
        state_d     = state_q;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end else if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    complete = 1'b1;
                    state_d  = ST_DONE;
                end else if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the winning PE's transaction when it is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= '0;
            grant_id_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant_now) begin
            id_q       <= pick_idx;
            grant_id_q <= pick_idx;
            we_q       <= pe_write[pick_idx];
            addr_q     <= pe_addr[int'(pick_idx)*AW +: AW];
            wdata_q    <= pe_wdata[int'(pick_idx)*DW +: DW];
        end
    end

    // Round-robin pointer advances only when a transaction finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(NUM_PE - 1);
        end else if (state_q == ST_DONE) begin
            last_grant_q <= id_q;
        end
    end

    // Timeout counter: restarts on entry to ISSUE, runs through ISSUE and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (grant_now) begin
            cnt_q <= '0;
        end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Read data register: holds until the next read finishes (forced or not).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (complete && !we_q) begin
            rdata_q <= mem_rdata;
        end else if (timeout_hit && !we_q) begin
            rdata_q <= {DW{DONE_RDATA_ON_TIMEOUT}};
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_proto_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (grant_now && pe_read[pick_idx] && pe_write[pick_idx]) begin
                err_proto_q <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    // Response pulses to the granted PE during DONE.
    always_comb begin
        pe_ack        = '0;
        pe_data_ready = '0;
        if (state_q == ST_DONE) begin
            pe_ack[id_q]        = 1'b1;
            pe_data_ready[id_q] = !we_q;
        end
    end

    assign mem_req     = (state_q == ST_ISSUE);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign pe_rdata    = rdata_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_proto   = err_proto_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Directed bench for pe_mem_arbiter with a cycle-timeline model and grant scoreboard.
module tb_pe_mem_arbiter;
    import cgra_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    pe_read, pe_write;
    logic [N*AW-1:0] pe_addr;
    logic [N*DW-1:0] pe_wdata;
    logic [N-1:0]    pe_ack, pe_data_ready;
    logic [DW-1:0]   pe_rdata;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready, mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      grant_id;
    logic            busy, err_proto, err_timeout;
    arb_state_e      dbg_state;

    pe_mem_arbiter #(.NUM_PE(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pe_read(pe_read), .pe_write(pe_write),
        .pe_addr(pe_addr), .pe_wdata(pe_wdata), .pe_ack(pe_ack),
        .pe_data_ready(pe_data_ready), .pe_rdata(pe_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy), .err_proto(err_proto),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory responder knobs
    int          rdy_delay   = 0;
    bit          never_ready = 0;
    bit          never_rv    = 0;
    logic [DW-1:0] rdata_val = 32'h0;
    int          req_age     = 0;
    bit          ready_prev  = 0;
    logic [N-1:0] ack_seen   = '0;
    int          req_hi_cnt  = 0;

    logic [1:0] exp_q[$];

    // model of the in-flight transaction, as a timeline in cycles since grant
    bit          m_active;
    int          m_age, m_done, m_last, m_id;
    bit          m_accepted, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]  m_gid;
    bit          m_err_proto, m_err_to;

    bit           a_done, e_req;
    logic [N-1:0] e_ack, e_dr;
    logic [1:0]   sb_id;

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_age       = 0;
        m_done      = -1;
        m_last      = N - 1;
        m_id        = 0;
        m_accepted  = 0;
        m_we        = 0;
        m_addr      = '0;
        m_wdata     = '0;
        m_rdata     = '0;
        m_gid       = '0;
        m_err_proto = 0;
        m_err_to    = 0;
    endtask

    // driver: PE auto-release on ack and memory responder, just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pe_read  = pe_read & ~ack_seen;
            pe_write = pe_write & ~ack_seen;
            if (!rst_n) begin
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                req_age    = 0;
                ready_prev = 0;
            end else begin
                mem_rvalid = ready_prev && !never_rv;
                mem_rdata  = mem_rvalid ? rdata_val : ~rdata_val;
                if (mem_req) begin
                    mem_ready = !never_ready && (req_age == rdy_delay);
                    req_age++;
                end else begin
                    mem_ready = 1'b0;
                    req_age   = 0;
                end
                ready_prev = mem_ready;
            end
        end
    end

    // compare process: model expectations vs DUT at every negedge
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                ack_seen = '0;
                check("rst_busy", busy, 0);
                check("rst_mem_req", mem_req, 0);
                check("rst_ack", pe_ack, 0);
                check("rst_dr", pe_data_ready, 0);
                check("rst_rdata", pe_rdata, 0);
                check("rst_errs", {err_proto, err_timeout}, 0);
                check("rst_gid", grant_id, 0);
            end else begin
                a_done = m_active && (m_age == m_done);
                e_req  = m_active && !a_done && !m_accepted;
                e_ack  = a_done ? (N'(1) << m_id) : '0;
                e_dr   = (a_done && !m_we) ? e_ack : '0;
                check("busy", busy, m_active);
                check("mem_req", mem_req, e_req);
                check("pe_ack", pe_ack, e_ack);
                check("pe_data_ready", pe_data_ready, e_dr);
                check("pe_rdata", pe_rdata, m_rdata);
                check("grant_id", grant_id, m_gid);
                check("err_proto", err_proto, m_err_proto);
                check("err_timeout", err_timeout, m_err_to);
                if (e_req) begin
                    check("mem_addr", mem_addr, m_addr);
                    check("mem_we", mem_we, m_we);
                    check("mem_wdata", mem_wdata, m_wdata);
                end
                if (pe_ack != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", pe_ack, 0);
                    end else begin
                        sb_id = exp_q.pop_front();
                        check("grant_order", pe_ack, N'(1) << sb_id);
                    end
                end
                // advance the model to the next cycle
                if (!m_active) begin
                    if ((pe_read | pe_write) != 0) begin
                        for (int k = N; k >= 1; k--) begin
                            if (pe_read[(m_last + k) % N] || pe_write[(m_last + k) % N]) begin
                                m_id = (m_last + k) % N;
                            end
                        end
                        m_active    = 1;
                        m_age       = 1;
                        m_done      = -1;
                        m_accepted  = 0;
                        m_gid       = 2'(m_id);
                        m_we        = pe_write[m_id];
                        m_addr      = pe_addr[m_id*AW +: AW];
                        m_wdata     = pe_wdata[m_id*DW +: DW];
                        m_err_proto = m_err_proto | (pe_read[m_id] & pe_write[m_id]);
                    end
                end else if (a_done) begin
                    m_active = 0;
                    m_last   = m_id;
                end else begin
                    if (!m_accepted) begin
                        if (m_age == TO) begin
                            m_done   = m_age + 1;
                            m_err_to = 1;
                            if (!m_we) m_rdata = '0;
                        end else if (mem_ready) begin
                            m_accepted = 1;
                        end
                    end else begin
                        if (mem_rvalid) begin
                            m_done = m_age + 1;
                            if (!m_we) m_rdata = mem_rdata;
                        end else if (m_age == TO) begin
                            m_done   = m_age + 1;
                            m_err_to = 1;
                            if (!m_we) m_rdata = '0;
                        end
                    end
                    m_age++;
                end
                if (mem_req) req_hi_cnt++;
                ack_seen = pe_ack;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pe_read     = '0;
        pe_write    = '0;
        rdy_delay   = 0;
        never_ready = 0;
        never_rv    = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pe_ack != 0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("ack_wait_expired", 0, 1);
    endtask

    int t0, ta;

    initial begin
        rst_n     = 1'b0;
        pe_read   = '0;
        pe_write  = '0;
        pe_addr   = '0;
        pe_wdata  = '0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;

        // reset state
        do_reset();
        step();
        check("idle_busy", busy, 0);
        check("idle_gid", grant_id, 0);
        check("idle_rdata", pe_rdata, 0);

        // single read, PE2 @0x100
        rdata_val = 32'hCAFEF00D;
        pe_addr[2*AW +: AW] = 32'h100;
        exp_q.push_back(2'd2);
        req_hi_cnt = 0;
        pe_read[2] = 1'b1;
        t0 = cyc;
        wait_ack(ta);
        check("rd_latency", ta - t0, 3);
        check("rd_ack", pe_ack, 4'b0100);
        check("rd_dr", pe_data_ready, 4'b0100);
        check("rd_data", pe_rdata, 32'hCAFEF00D);
        check("rd_req_cycles", req_hi_cnt, 1);

        // single write, PE1 0x55 -> 0x40, mem_ready after 3 waits
        step();
        step();
        rdy_delay = 3;
        pe_addr[1*AW +: AW]  = 32'h40;
        pe_wdata[1*DW +: DW] = 32'h55;
        exp_q.push_back(2'd1);
        req_hi_cnt = 0;
        pe_write[1] = 1'b1;
        t0 = cyc;
        wait_ack(ta);
        check("wr_latency", ta - t0, 6);
        check("wr_ack", pe_ack, 4'b0010);
        check("wr_dr", pe_data_ready, 0);
        check("wr_req_cycles", req_hi_cnt, 4);
        check("wr_rdata_held", pe_rdata, 32'hCAFEF00D);

        // round-robin from reset, PE0 re-requests while PE3 is granted
        do_reset();
        step();
        rdy_delay = 0;
        rdata_val = 32'h1234_5678;
        for (int i = 0; i < N; i++) pe_addr[i*AW +: AW] = 32'h1000 * i;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        pe_read = 4'b1111;
        for (int i = 0; i < 3; i++) wait_ack(ta);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && grant_id == 2'd3) break;
        end
        step();
        pe_read[0] = 1'b1;
        wait_ack(ta);
        check("rr_ack3", pe_ack, 4'b1000);
        wait_ack(ta);
        check("rr_ack0_again", pe_ack, 4'b0001);

        // read and write together on PE3
        step();
        pe_addr[3*AW +: AW]  = 32'h80;
        pe_wdata[3*DW +: DW] = 32'hBEEF;
        exp_q.push_back(2'd3);
        pe_read[3]  = 1'b1;
        pe_write[3] = 1'b1;
        wait_ack(ta);
        check("proto_dr", pe_data_ready, 0);
        check("proto_flag", err_proto, 1);

        // timeout in ISSUE: memory never ready
        step();
        never_ready = 1;
        pe_addr[0] = 32'h200;
        exp_q.push_back(2'd0);
        req_hi_cnt = 0;
        pe_read[0] = 1'b1;
        t0 = cyc;
        wait_ack(ta);
        check("to_latency", ta - t0, 9);
        check("to_rdata", pe_rdata, 0);
        check("to_flag", err_timeout, 1);
        check("to_mem_req", mem_req, 0);
        check("to_req_cycles", req_hi_cnt, 8);
        check("to_dr", pe_data_ready, 4'b0001);

        // timeout in WAIT: accepted but never completed
        step();
        never_ready = 0;
        never_rv    = 1;
        exp_q.push_back(2'd1);
        pe_write[1] = 1'b1;
        t0 = cyc;
        wait_ack(ta);
        check("to_wait_latency", ta - t0, 9);
        check("proto_sticky", err_proto, 1);

        // reset asserted while waiting for completion
        step();
        pe_read[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT) break;
        end
        check("reached_wait", busy, 1);
        step();
        rst_n    = 1'b0;
        pe_read  = '0;
        pe_write = '0;
        #1;
        check("async_busy", busy, 0);
        check("async_mem_req", mem_req, 0);
        check("async_ack", pe_ack, 0);
        check("async_errs", {err_proto, err_timeout}, 0);
        check("async_rdata", pe_rdata, 0);
        check("async_gid", grant_id, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        never_rv = 0;
        step();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        pe_read[0] = 1'b1;
        pe_read[3] = 1'b1;
        wait_ack(ta);
        check("post_rst_first", pe_ack, 4'b0001);
        wait_ack(ta);
        check("post_rst_second", pe_ack, 4'b1000);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
Shares the single data-memory port of a CGRA tile among NUM_PE processing elements. Each PE issues mem_read/mem_write with an address and waits for mem_ack/data_Ready, matching the PE memory handshake. The arbiter grants one PE at a time in round-robin order, sequences the transaction to memory, returns the response, and flags protocol and timeout errors. It sits between the PE array and the tile data memory.

Parameters:
NUM_PE, 4, number of requesting PEs (2..16)
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles in ISSUE+WAIT before forced completion

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pe_read  in  NUM_PE  per-PE read request, held until ack
pe_write  in  NUM_PE  per-PE write request, held until ack
pe_addr  in  NUM_PE*AW  per-PE address, slice i = PE i
pe_wdata  in  NUM_PE*DW  per-PE write data
pe_ack  out  NUM_PE  one-cycle completion pulse to granted PE
pe_data_ready  out  NUM_PE  one-cycle read-data-valid pulse (reads only)
pe_rdata  out  DW  read data, shared, valid with pe_data_ready, held until next read completes
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory completion (read data valid / write done)
mem_rdata  in  DW  memory read data
grant_id  out  log2(NUM_PE)  index of current/last granted PE
busy  out  1  high in any state except IDLE
err_proto  out  1  sticky: a PE asserted read and write together
err_timeout  out  1  sticky: a transaction hit TIMEOUT

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; last_grant = NUM_PE-1 (PE0 has top priority first); timeout counter 0; sticky errors cleared. Reset mid-transaction abandons it; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_vec = pe_read | pe_write. If nonzero, pick the first set bit searching from last_grant+1 upward with wrap; latch id, addr, wdata, we (= pe_write[id]); -> ISSUE. Requests are sampled only in IDLE.
- Read and write both set for the same PE: treated as write, err_proto set.
- ISSUE: mem_req=1 with latched addr/we/wdata; on mem_ready -> WAIT. Outputs stable while mem_req=1 and mem_ready=0.
- WAIT: on mem_rvalid capture mem_rdata if read; -> DONE. A mem_rvalid in the same cycle as mem_ready is not accepted; completion counts only from WAIT.
- DONE: pe_ack[id]=1 for exactly one cycle; pe_data_ready[id]=1 and pe_rdata updated if read; last_grant=id; -> IDLE.
- PE deasserts its request on the edge where it sees ack, so the next IDLE cycle does not re-grant the same transaction.
- Latency: request visible in IDLE at cycle T; mem_req at T+1; with mem_ready at T+1 and mem_rvalid at T+2, ack at T+3. Back-to-back grants cost 4 cycles minimum per transaction.
- Timeout: counter counts ISSUE+WAIT cycles and reloads on entry to ISSUE. When it reaches TIMEOUT-1 without completion, go to DONE, ack the PE, pe_rdata=0 for a read, set err_timeout, drop mem_req. A late mem_rvalid in IDLE is ignored.
- Fairness: with all PEs requesting continuously, grant order is 0,1,2,...,NUM_PE-1,0. No PE waits more than NUM_PE-1 transactions.
- grant_id updates on entry to ISSUE; busy = (state != IDLE).

Decomposition:
- Package cgra_mem_pkg: FSM state enum, AW/DW defaults, TIMEOUT default, DONE_RDATA_ON_TIMEOUT constant (0).
- One sub-module, rr_pick: combinational round-robin picker (req_vec, last_grant -> found, idx).

Test Plan:
- Single read: PE2 reads 0x100; mem_ready immediately, mem_rvalid next cycle with 0xCAFEF00D -> mem_req one cycle, pe_ack[2] and pe_data_ready[2] at T+3, pe_rdata=0xCAFEF00D.
- Single write: PE1 writes 0x55 to 0x40 with mem_ready delayed 3 cycles -> mem_req/mem_addr/mem_wdata held stable 4 cycles, mem_we=1, pe_ack[1] pulse, pe_data_ready stays 0.
- Round-robin: all 4 PEs read from reset -> grants 0,1,2,3. PE0 re-requests during PE3's grant -> PE0 granted next.
- Simultaneous read+write on PE3 -> a write is issued, err_proto=1 and stays 1.
- Timeout with TIMEOUT=8: mem_ready never asserts -> after 8 cycles pe_ack pulses, pe_rdata=0, err_timeout=1, mem_req=0.
- Reset asserted in WAIT -> outputs 0 immediately (async). After release, PE0 wins over PE3 when both request.
